// File: rtl/ib_pkg.sv
// Shared types for the dual-issue instruction buffer.
// Entry width, default depth and two-lane request encodings.
package ib_pkg;

  localparam int IB_ENTRY_W = 71;
  localparam int IB_DEPTH   = 16;

  typedef logic [IB_ENTRY_W-1:0] ib_entry_t;

  typedef enum logic [1:0] {
    LANES_NONE = 2'b00,
    LANES_ONE  = 2'b01,
    LANES_TWO  = 2'b11
  } lanes_e;

  // 2'b10 is not a legal form and counts as no lanes
  function automatic logic [1:0] lane_cnt(input logic [1:0] v);
    unique case (v)
      LANES_ONE: lane_cnt = 2'd1;
      LANES_TWO: lane_cnt = 2'd2;
      default:   lane_cnt = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ib_fifo_ram_2w2r.sv
// Instruction buffer storage: two write ports, two async read ports.
// Array is not reset; pointers in the parent decide what is live.
module ib_fifo_ram_2w2r #(
  parameter int DATA_W = 71,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/ib_fifo_dual.sv
// Dual-issue instruction buffer between fetch and the two decoders.
// Two-wide push/pop with same-cycle bypass into registered outputs.
module ib_fifo_dual
  import ib_pkg::*;
#(
  parameter int DATA_W = IB_ENTRY_W,
  parameter int DEPTH  = IB_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic [1:0]        wr_valid,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic              wr_ready,
  input  logic [1:0]        rd_en,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic [1:0]        rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              overflow
);

  localparam int CW = ADDR_W + 1;

  logic [ADDR_W-1:0] wptr, rptr;
  logic [1:0]        nwr_req, nwr, nrd;
  logic [1:0]        npop, nsto, nbyp, nput;
  logic [CW-1:0]     avail;
  logic              ovf_hit;
  logic              we0, we1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] mem_d0, mem_d1;
  logic [DATA_W-1:0] src0, src1;

  assign wr_ready = (count <= CW'(DEPTH - 2));
  assign empty    = (count == '0);

  always_comb begin
    nwr_req = lane_cnt(wr_valid);
    ovf_hit = !wr_ready && (nwr_req != 2'd0);
    nwr     = wr_ready ? nwr_req : 2'd0;
    nrd     = stall ? 2'd0 : lane_cnt(rd_en);
    avail   = count + CW'(nwr);
    npop    = (avail < CW'(nrd)) ? avail[1:0] : nrd;
    // stored entries are older than this cycle's push
    nsto    = (count < CW'(npop)) ? count[1:0] : npop;
    nbyp    = npop - nsto;
    nput    = nwr - nbyp;
    we0     = !flush && (nput != 2'd0);
    we1     = !flush && (nput == 2'd2);
    wdata0  = (nbyp == 2'd0) ? wr_data0 : wr_data1;
    src0    = (count != '0) ? mem_d0 : wr_data0;
    src1    = mem_d1;
    if (count == CW'(1)) src1 = wr_data0;
    else if (count == '0) src1 = wr_data1;
  end

  ib_fifo_ram_2w2r #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we0    (we0),
    .waddr0 (wptr),
    .wdata0 (wdata0),
    .we1    (we1),
    .waddr1 (wptr + ADDR_W'(1)),
    .wdata1 (wr_data1),
    .raddr0 (rptr),
    .rdata0 (mem_d0),
    .raddr1 (rptr + ADDR_W'(1)),
    .rdata1 (mem_d1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wptr     <= wptr + ADDR_W'(nput);
      rptr     <= rptr + ADDR_W'(nsto);
      count    <= count + CW'(nwr) - CW'(npop);
      overflow <= overflow | ovf_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data0 <= '0;
      rd_data1 <= '0;
      rd_valid <= 2'b00;
    end else if (flush) begin
      rd_data0 <= '0;
      rd_data1 <= '0;
      rd_valid <= 2'b00;
    end else if (!stall) begin
      rd_valid <= {npop == 2'd2, npop != 2'd0};
      rd_data0 <= (npop != 2'd0) ? src0 : '0;
      rd_data1 <= (npop == 2'd2) ? src1 : '0;
    end
  end

endmodule

// File: tb/tb_ib_fifo_dual.sv
// Self-checking bench for ib_fifo_dual.
// Queue-based reference model plus directed and random scenarios.
module tb_ib_fifo_dual;
  import ib_pkg::*;

  localparam int W = IB_ENTRY_W;
  localparam int D = IB_DEPTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         stall = 1'b0;
  logic [1:0]   wr_valid = 2'b00;
  logic [W-1:0] wr_data0 = '0;
  logic [W-1:0] wr_data1 = '0;
  logic         wr_ready;
  logic [1:0]   rd_en = 2'b00;
  logic [W-1:0] rd_data0, rd_data1;
  logic [1:0]   rd_valid;
  logic [4:0]   count;
  logic         empty;
  logic         overflow;

  ib_fifo_dual dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall    (stall),
    .wr_valid (wr_valid),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .wr_ready (wr_ready),
    .rd_en    (rd_en),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1),
    .rd_valid (rd_valid),
    .count    (count),
    .empty    (empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] exp_d0 = '0, exp_d1 = '0;
  logic [1:0]   exp_v = 2'b00;
  logic         exp_ovf = 1'b0;

  function automatic int lanes(input logic [1:0] v);
    if (v == 2'b01) return 1;
    if (v == 2'b11) return 2;
    return 0;
  endfunction

  function automatic logic [W-1:0] rnd();
    return W'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic model(input logic fl, input logic st,
                       input logic [1:0] wv, input logic [1:0] re,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] seq[$];
    int nw, nr;
    if (fl) begin
      q.delete();
      exp_d0 = '0; exp_d1 = '0; exp_v = 2'b00; exp_ovf = 1'b0;
    end else begin
      nw = lanes(wv);
      seq = q;
      if (nw > 0) begin
        if (q.size() <= D - 2) begin
          seq.push_back(a);
          if (nw == 2) seq.push_back(b);
        end else exp_ovf = 1'b1;
      end
      if (!st) begin
        nr = lanes(re);
        exp_d0 = '0; exp_d1 = '0; exp_v = 2'b00;
        if (nr >= 1 && seq.size() >= 1) begin
          exp_d0 = seq.pop_front(); exp_v[0] = 1'b1;
        end
        if (nr >= 2 && seq.size() >= 1) begin
          exp_d1 = seq.pop_front(); exp_v[1] = 1'b1;
        end
      end
      q = seq;
    end
  endtask

  task automatic drive(input logic fl, input logic st,
                       input logic [1:0] wv, input logic [1:0] re,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    flush = fl; stall = st; wr_valid = wv; rd_en = re;
    wr_data0 = a; wr_data1 = b;
    @(posedge clk);
    model(fl, st, wv, re, a, b);
    #1;
    flush = 1'b0; stall = 1'b0; wr_valid = 2'b00; rd_en = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    exp_d0 = '0; exp_d1 = '0; exp_v = 2'b00; exp_ovf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (rd_valid !== 2'b00 || rd_data0 !== '0 || rd_data1 !== '0) begin
      nerr++;
      $display("FAIL reset_out got v=%b d0=%h d1=%h want 0", rd_valid, rd_data0, rd_data1);
    end
    nvec++;
    if (count !== 5'd0 || empty !== 1'b1 || wr_ready !== 1'b1 || overflow !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state got cnt=%0d e=%b rdy=%b ovf=%b want 0 1 1 0", count, empty, wr_ready, overflow);
    end
  endtask

  task automatic test_basic_order();
    logic [W-1:0] a, b;
    do_reset();
    a = rnd(); b = rnd();
    drive(0, 0, 2'b11, 2'b00, a, b);
    nvec++;
    if (count !== 5'd2) begin
      nerr++; $display("FAIL basic_push count got %0d want 2", count);
    end
    drive(0, 0, 2'b00, 2'b11, '0, '0);
    nvec++;
    if (rd_data0 !== a || rd_data1 !== b || rd_valid !== 2'b11) begin
      nerr++;
      $display("FAIL basic_pop got %h %h v=%b want %h %h 11", rd_data0, rd_data1, rd_valid, a, b);
    end
    nvec++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      nerr++; $display("FAIL basic_empty got cnt=%0d e=%b want 0 1", count, empty);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++)
      drive(0, 0, 2'b11, 2'b00, W'(100 + 2 * i), W'(101 + 2 * i));
    nvec++;
    if (count !== 5'd16 || wr_ready !== 1'b0) begin
      nerr++; $display("FAIL fill_full got cnt=%0d rdy=%b want 16 0", count, wr_ready);
    end
    drive(0, 0, 2'b01, 2'b00, W'(999), '0);
    nvec++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      nerr++; $display("FAIL fill_ovf got ovf=%b cnt=%0d want 1 16", overflow, count);
    end
    drive(0, 0, 2'b00, 2'b11, '0, '0);
    nvec++;
    if (count !== 5'd14 || wr_ready !== 1'b1 || overflow !== 1'b1) begin
      nerr++; $display("FAIL fill_pop got cnt=%0d rdy=%b ovf=%b want 14 1 1", count, wr_ready, overflow);
    end
    nvec++;
    if (rd_data0 !== W'(100) || rd_data1 !== W'(101)) begin
      nerr++; $display("FAIL fill_order got %0d %0d want 100 101", rd_data0, rd_data1);
    end
  endtask

  task automatic test_bypass();
    logic [W-1:0] c;
    do_reset();
    c = rnd();
    drive(0, 0, 2'b01, 2'b11, c, rnd());
    nvec++;
    if (rd_data0 !== c || rd_valid !== 2'b01 || rd_data1 !== '0 || count !== 5'd0) begin
      nerr++;
      $display("FAIL bypass got d0=%h v=%b d1=%h cnt=%0d want %h 01 0 0", rd_data0, rd_valid, rd_data1, count, c);
    end
  endtask

  task automatic test_mixed_bypass();
    logic [W-1:0] d, e, f;
    do_reset();
    d = rnd(); e = rnd(); f = rnd();
    drive(0, 0, 2'b01, 2'b00, d, '0);
    drive(0, 0, 2'b11, 2'b11, e, f);
    nvec++;
    if (rd_data0 !== d || rd_data1 !== e || rd_valid !== 2'b11 || count !== 5'd1) begin
      nerr++;
      $display("FAIL mixed got %h %h v=%b cnt=%0d want %h %h 11 1", rd_data0, rd_data1, rd_valid, count, d, e);
    end
    drive(0, 0, 2'b00, 2'b01, '0, '0);
    nvec++;
    if (rd_data0 !== f || rd_valid !== 2'b01 || empty !== 1'b1) begin
      nerr++; $display("FAIL mixed_tail got %h v=%b e=%b want %h 01 1", rd_data0, rd_valid, empty, f);
    end
  endtask

  task automatic test_stall_wrap();
    logic [W-1:0] x, y;
    do_reset();
    x = rnd(); y = rnd();
    drive(0, 0, 2'b11, 2'b11, x, y);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, 2'b11, 2'b11, W'(200 + 2 * i), W'(201 + 2 * i));
      nvec++;
      if (rd_data0 !== x || rd_data1 !== y || rd_valid !== 2'b11 || count !== 5'(2 * i)) begin
        nerr++;
        $display("FAIL stall_hold got %h %h v=%b cnt=%0d want %h %h 11 %0d", rd_data0, rd_data1, rd_valid, count, x, y, 2 * i);
      end
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 2'b00, 2'b11, '0, '0);
    // pointers now sit at 6; push/pop through 15->0
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 2'b11, (i > 1) ? 2'b11 : 2'b00, W'(300 + 2 * i), W'(301 + 2 * i));
      nvec++;
      if (rd_data0 !== exp_d0 || rd_data1 !== exp_d1 || rd_valid !== exp_v || count !== 5'(q.size())) begin
        nerr++;
        $display("FAIL wrap got %0d %0d v=%b cnt=%0d want %0d %0d %b %0d", rd_data0, rd_data1, rd_valid, count, exp_d0, exp_d1, exp_v, q.size());
      end
    end
  endtask

  task automatic test_flush_rst();
    do_reset();
    for (int i = 0; i < 8; i++) drive(0, 0, 2'b11, 2'b00, rnd(), rnd());
    drive(0, 0, 2'b01, 2'b00, rnd(), '0);
    for (int i = 0; i < 3; i++) drive(0, 0, 2'b00, 2'b11, '0, '0);
    drive(0, 0, 2'b00, 2'b01, '0, '0);
    nvec++;
    if (count !== 5'd9 || overflow !== 1'b1 || rd_valid !== 2'b01) begin
      nerr++; $display("FAIL flush_pre got cnt=%0d ovf=%b v=%b want 9 1 01", count, overflow, rd_valid);
    end
    drive(1, 0, 2'b11, 2'b11, rnd(), rnd());
    nvec++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 2'b00 || rd_data0 !== '0 || rd_data1 !== '0) begin
      nerr++;
      $display("FAIL flush got cnt=%0d e=%b ovf=%b v=%b d0=%h want 0 1 0 00 0", count, empty, overflow, rd_valid, rd_data0);
    end
    drive(0, 0, 2'b11, 2'b00, rnd(), rnd());
    drive(0, 0, 2'b01, 2'b11, rnd(), '0);
    #3 rst = 1'b1;
    #1;
    nvec++;
    if (rd_valid !== 2'b00 || rd_data0 !== '0 || count !== 5'd0 || empty !== 1'b1) begin
      nerr++;
      $display("FAIL async_rst got v=%b d0=%h cnt=%0d e=%b want 00 0 0 1", rd_valid, rd_data0, count, empty);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [1:0] wv, re;
    logic       fl, st;
    int         r, hi;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      hi = ((i / 150) % 2 == 0) ? 7 : 3;
      r  = $urandom_range(0, 9);
      wv = (r == 0) ? 2'b10 : (r < hi) ? 2'b11 : (r < hi + 2) ? 2'b01 : 2'b00;
      r  = $urandom_range(0, 9);
      re = (r == 0) ? 2'b10 : (r < 10 - hi) ? 2'b11 : (r < 12 - hi) ? 2'b01 : 2'b00;
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 99) == 0);
      drive(fl, st, wv, re, rnd(), rnd());
      nvec++;
      if (rd_data0 !== exp_d0 || rd_data1 !== exp_d1 || rd_valid !== exp_v) begin
        nerr++;
        $display("FAIL rand_out @%0d got %h %h v=%b want %h %h %b", i, rd_data0, rd_data1, rd_valid, exp_d0, exp_d1, exp_v);
      end
      nvec++;
      if (count !== 5'(q.size()) || empty !== (q.size() == 0) || wr_ready !== (q.size() <= D - 2) || overflow !== exp_ovf) begin
        nerr++;
        $display("FAIL rand_state @%0d got cnt=%0d e=%b rdy=%b ovf=%b want cnt=%0d ovf=%b", i, count, empty, wr_ready, overflow, q.size(), exp_ovf);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic_order();
    test_fill();
    test_bypass();
    test_mixed_bypass();
    test_stall_wrap();
    test_flush_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
